// File: rtl/regfile_scoreboard_if.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard_if
// Bundles the read, writeback, issue and status signals of the register file
// with scoreboard. clk and rst_n are not part of the bundle.
//
//   rs1_addr/rs2_addr   read-port register indices       (master -> slave)
//   rs1_data/rs2_data   read-port data                    (slave -> master)
//   rs1_busy/rs2_busy   read source has a pending producer (slave -> master)
//   stall               rs1_busy | rs2_busy               (slave -> master)
//   wr_en/addr/data     writeback port, clears busy       (master -> slave)
//   iss_en/iss_rd       issue port, marks iss_rd pending  (master -> slave)
//   busy_cnt            number of pending registers       (slave -> master)
// ---------------------------------------------------------------------------
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              stall;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_rd;
  logic [ADDR_W:0]   busy_cnt;

  // Pipeline side: drives indices, writeback and issue; observes results.
  modport master (
    output rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, stall, busy_cnt
  );

  // Register file side.
  modport slave (
    input  rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, stall, busy_cnt
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// Two-read / one-write register file with a per-register busy scoreboard.
// Reads are combinational. A write stores data and retires the pending
// producer of that register; an issue marks its destination pending.
// Register 0 is hardwired to zero and is never pending.
//
// Ports:
//   clk    single clock, all state updates on the rising edge
//   rst_n  asynchronous active-low reset; clears data, busy bits and count
//   bus    regfile_scoreboard_if.slave (read, writeback, issue, status)
//
// Build option:
//   REGFILE_WR_BYPASS_EN  when defined, a same-cycle write to a read index is
//                         forwarded to that read port and hides its busy bit
//                         (unless the same register is re-issued that cycle).
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_scoreboard_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [ADDR_W:0]   busy_cnt_q;

  // Writes/issues aimed at register 0 are discarded up front so that the
  // storage and scoreboard never see them.
  logic wr_ok;
  logic iss_ok;
  logic same_reg;
  logic cnt_inc;
  logic cnt_dec;

  assign wr_ok    = bus.wr_en  && (bus.wr_addr != '0);
  assign iss_ok   = bus.iss_en && (bus.iss_rd  != '0);
  assign same_reg = wr_ok && iss_ok && (bus.wr_addr == bus.iss_rd);

  // Count tracks the popcount incrementally: only a fresh issue adds, and a
  // writeback only subtracts if it really retires a pending producer that is
  // not being replaced on the same edge.
  assign cnt_inc = iss_ok && !busy_q[bus.iss_rd];
  assign cnt_dec = wr_ok  &&  busy_q[bus.wr_addr] && !same_reg;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the data array is deliberately reset: the register file must read
  // all zeros straight out of reset and a reset must drop in-flight writes,
  // so this cannot be mapped to a plain un-reset RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  // NOTE: both updates are non-blocking to the same vector; when a writeback
  // and an issue hit the same register, the later assignment (the set) wins,
  // which is exactly "new producer keeps it busy".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      if (wr_ok)  busy_q[bus.wr_addr] <= 1'b0;
      if (iss_ok) busy_q[bus.iss_rd]  <= 1'b1;
      busy_cnt_q <= busy_cnt_q + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];
  logic              rd_busy [2];

  assign rd_addr[0] = bus.rs1_addr;
  assign rd_addr[1] = bus.rs2_addr;

  // NOTE: every output gets a default at the top of the block so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = regs[rd_addr[p]];
      rd_busy[p] = busy_q[rd_addr[p]];
      if (rd_addr[p] == '0) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
`ifdef REGFILE_WR_BYPASS_EN
      // Forward the value being written this cycle; the producer is done
      // unless the same register is being re-issued on this edge.
      if (wr_ok && (bus.wr_addr == rd_addr[p])) begin
        rd_data[p] = bus.wr_data;
        if (!(iss_ok && (bus.iss_rd == rd_addr[p]))) rd_busy[p] = 1'b0;
      end
`endif
      // Outputs are forced quiet while reset is held, independent of any
      // bypass path driven from the still-active inputs.
      if (!rst_n) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end

  assign bus.rs1_data = rd_data[0];
  assign bus.rs2_data = rd_data[1];
  assign bus.rs1_busy = rd_busy[0];
  assign bus.rs2_busy = rd_busy[1];
  assign bus.stall    = rd_busy[0] | rd_busy[1];
  assign bus.busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_regfile_scoreboard
// Directed bench for regfile_scoreboard. Each expected value is pushed onto
// a queue when the stimulus producing it is applied, and popped and compared
// when the DUT output is sampled. Inputs change and outputs are sampled 1 ns
// or more after the rising edge.
// ---------------------------------------------------------------------------
module tb_regfile_scoreboard;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic clk;
  logic rst_n;

  regfile_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   passed;
  int   failed;

  task automatic push(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [63:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      failed++;
      $error("FAIL scoreboard_empty: observed=%0h required=<queued value>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) begin
        passed++;
      end else begin
        failed++;
        $error("FAIL %s: observed=%0h required=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  // Expect-and-compare in one call for outputs sampled right away.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    push(tag, exp);
    pop_check(obs);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en  = 1'b0;
    bus.iss_en = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    total  = 0;
    passed = 0;
    failed = 0;

    // ---- Reset, with writes/issues driven that must be ignored ----------
    rst_n        = 1'b0;
    bus.rs1_addr = 5'd5;
    bus.rs2_addr = 5'd6;
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 5'd5;
    bus.wr_data  = 32'hFFFF_FFFF;
    bus.iss_en   = 1'b1;
    bus.iss_rd   = 5'd6;
    #2;
    chk("rst_rs1_data", 64'(bus.rs1_data), 64'h0);
    chk("rst_stall",    64'(bus.stall),    64'h0);
    step();
    chk("rst_cnt_edge", 64'(bus.busy_cnt), 64'h0);
    chk("rst_rs2_busy", 64'(bus.rs2_busy), 64'h0);
    idle();
    step();
    rst_n = 1'b1;

    // ---- Every index reads zero after reset -----------------------------
    for (int i = 0; i < 32; i++) begin
      bus.rs1_addr = 5'(i);
      bus.rs2_addr = 5'(31 - i);
      push("reset_rd1", 64'h0);
      push("reset_rd2", 64'h0);
      #1;
      pop_check(64'(bus.rs1_data));
      pop_check(64'(bus.rs2_data));
    end
    chk("reset_cnt", 64'(bus.busy_cnt), 64'h0);

    // ---- Write r5, attempt write r0 -------------------------------------
    step();
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd5;
    bus.wr_data = 32'hDEAD_BEEF;
    push("wr_r5", 64'hDEAD_BEEF);
    step();
    bus.wr_addr = 5'd0;
    bus.wr_data = 32'h0000_1234;
    push("wr_r0", 64'h0);
    step();
    idle();
    bus.rs1_addr = 5'd5;
    bus.rs2_addr = 5'd0;
    #1;
    pop_check(64'(bus.rs1_data));
    pop_check(64'(bus.rs2_data));
    chk("wr_nonbusy_cnt", 64'(bus.busy_cnt), 64'h0);

    // ---- Issue r7, r9, r7 (WAW), then an ignored issue of r0 -------------
    bus.iss_en = 1'b1;
    bus.iss_rd = 5'd7;
    step();
    chk("iss_cnt1", 64'(bus.busy_cnt), 64'd1);
    bus.iss_rd = 5'd9;
    step();
    chk("iss_cnt2", 64'(bus.busy_cnt), 64'd2);
    bus.iss_rd = 5'd7;
    step();
    chk("waw_cnt", 64'(bus.busy_cnt), 64'd2);
    bus.iss_rd = 5'd0;
    step();
    idle();
    chk("iss_r0_cnt", 64'(bus.busy_cnt), 64'd2);
    bus.rs1_addr = 5'd7;
    bus.rs2_addr = 5'd0;
    #1;
    chk("r7_stall",   64'(bus.stall),    64'd1);
    chk("r7_busy",    64'(bus.rs1_busy), 64'd1);
    chk("r0_busy",    64'(bus.rs2_busy), 64'd0);

    // ---- Writeback r7 ---------------------------------------------------
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd7;
    bus.wr_data = 32'h0000_0077;
    step();
    idle();
    chk("wb_r7_cnt",   64'(bus.busy_cnt), 64'd1);
    chk("wb_r7_stall", 64'(bus.stall),    64'd0);
    chk("wb_r7_data",  64'(bus.rs1_data), 64'h77);
    bus.rs2_addr = 5'd9;
    #1;
    chk("r9_stall", 64'(bus.stall), 64'd1);

    // ---- Same-edge issue and writeback of busy r3 -----------------------
    bus.iss_en = 1'b1;
    bus.iss_rd = 5'd3;
    step();
    chk("iss_r3_cnt", 64'(bus.busy_cnt), 64'd2);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd3;
    bus.wr_data = 32'h0000_00A5;
    push("same_r3_data", 64'hA5);
    push("same_r3_busy", 64'd1);
    push("same_r3_cnt",  64'd2);
    step();
    idle();
    bus.rs1_addr = 5'd3;
    #1;
    pop_check(64'(bus.rs1_data));
    pop_check(64'(bus.rs1_busy));
    pop_check(64'(bus.busy_cnt));

    // ---- Read of busy r4 while it is being written ----------------------
    bus.iss_en = 1'b1;
    bus.iss_rd = 5'd4;
    step();
    idle();
    chk("iss_r4_cnt", 64'(bus.busy_cnt), 64'd3);
    bus.rs1_addr = 5'd4;
    bus.rs2_addr = 5'd0;
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 5'd4;
    bus.wr_data  = 32'h0000_0055;
    #1;
`ifdef REGFILE_WR_BYPASS_EN
    chk("byp_r4_data",  64'(bus.rs1_data), 64'h55);
    chk("byp_r4_stall", 64'(bus.stall),    64'd0);
`else
    chk("nobyp_r4_data",  64'(bus.rs1_data), 64'h0);
    chk("nobyp_r4_stall", 64'(bus.stall),    64'd1);
`endif
    step();
    idle();
    chk("wb_r4_data",  64'(bus.rs1_data), 64'h55);
    chk("wb_r4_stall", 64'(bus.stall),    64'd0);
    chk("wb_r4_cnt",   64'(bus.busy_cnt), 64'd2);

    // ---- Issue r12 while retiring r9 on the same edge -------------------
    bus.iss_en  = 1'b1;
    bus.iss_rd  = 5'd12;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd9;
    bus.wr_data = 32'h0000_0099;
    step();
    idle();
    bus.rs1_addr = 5'd12;
    bus.rs2_addr = 5'd9;
    #1;
    chk("mix_cnt",     64'(bus.busy_cnt), 64'd2);
    chk("mix_r12_busy",64'(bus.rs1_busy), 64'd1);
    chk("mix_r9_busy", 64'(bus.rs2_busy), 64'd0);
    chk("mix_r9_data", 64'(bus.rs2_data), 64'h99);

    // ---- Issue r1..r10, then reset mid-cycle ----------------------------
    bus.iss_en = 1'b1;
    for (int r = 1; r <= 10; r++) begin
      bus.iss_rd = 5'(r);
      step();
    end
    idle();
    // Pending: r1..r10 plus r12 (r3 was already pending).
    chk("iss10_cnt", 64'(bus.busy_cnt), 64'd11);
    bus.rs1_addr = 5'd1;
    bus.rs2_addr = 5'd5;
    #1;
    chk("pre_rst_stall", 64'(bus.stall), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_cnt",   64'(bus.busy_cnt), 64'd0);
    chk("midrst_stall", 64'(bus.stall),    64'd0);
    chk("midrst_data",  64'(bus.rs2_data), 64'h0);
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_r5",  64'(bus.rs2_data), 64'h0);
    chk("post_rst_cnt", 64'(bus.busy_cnt), 64'd0);

    // ---- First issue after reset release takes effect on the next edge --
    bus.iss_en = 1'b1;
    bus.iss_rd = 5'd2;
    step();
    idle();
    bus.rs1_addr = 5'd2;
    #1;
    chk("first_iss_cnt",  64'(bus.busy_cnt), 64'd1);
    chk("first_iss_busy", 64'(bus.rs1_busy), 64'd1);

    if (sb.size() != 0) begin
      total++;
      failed++;
      $display("FAIL scoreboard_leftover: observed=%0d required=0", sb.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 5, meaning register index width; depth = 2**ADDR_W.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL provide ports rs1_addr, rs2_addr  input  ADDR_W  read-port register indices.
REQ-006 SHALL provide ports rs1_data, rs2_data  output  DATA_W  read-port data.
REQ-007 SHALL provide ports rs1_busy, rs2_busy  output  1  read source has a pending producer.
REQ-008 SHALL provide port stall  output  1  rs1_busy OR rs2_busy.
REQ-009 SHALL provide ports wr_en (1), wr_addr (ADDR_W), wr_data (DATA_W)  input  writeback port.
REQ-010 SHALL provide ports iss_en (1), iss_rd (ADDR_W)  input  issue: mark iss_rd as pending.
REQ-011 SHALL provide port busy_cnt  output  ADDR_W+1  number of registers currently pending.

Function
REQ-012 Reads SHALL be combinational from the storage array; zero-cycle latency.
REQ-013 Write SHALL update reg[wr_addr] with wr_data at the rising edge when wr_en=1; visible on reads the following cycle.
REQ-014 Register 0 SHALL always read 0, ignore writes, and never be busy; iss_rd=0 is ignored.
REQ-015 Scoreboard: iss_en=1 SHALL set busy[iss_rd] at the edge; wr_en=1 SHALL clear busy[wr_addr] at the edge.
REQ-016 Simultaneous iss_en and wr_en to the same nonzero register SHALL leave busy set (new producer wins); data is still written.
REQ-017 Issue to an already-busy register (WAW) SHALL keep it busy with busy_cnt unchanged.
REQ-018 Write to a non-busy register SHALL be accepted with busy_cnt unchanged.
REQ-019 busy_cnt SHALL equal the population count of busy bits every cycle; +1, -1 or 0 net per edge; never wraps (max 2**ADDR_W-1).
REQ-020 rsN_busy SHALL equal busy[rsN_addr] (subject to REQ-026); stall SHALL be purely combinational.

Reset
REQ-021 rst_n=0 SHALL asynchronously clear all registers to 0, all busy bits to 0, busy_cnt to 0.
REQ-022 While rst_n=0, rs1_data=rs2_data=0, rs1_busy=rs2_busy=stall=0; wr_en and iss_en SHALL be ignored.
REQ-023 Reset asserted mid-operation SHALL discard all pending scoreboard state; no in-flight write survives.
REQ-024 First write/issue SHALL take effect on the first rising edge after rst_n deasserts.

Configuration
REQ-025 Macro REGFILE_WR_BYPASS_EN SHALL select same-cycle write-to-read forwarding.
REQ-026 With it defined: when wr_en=1 and wr_addr=rsN_addr≠0, rsN_data SHALL equal wr_data and rsN_busy SHALL be 0 in that cycle, unless iss_en=1 with iss_rd=rsN_addr (busy stays 1).
REQ-027 Without it: reads SHALL return stored data only, and rsN_busy follows busy[] unmodified; a same-cycle write is visible next cycle.

Verification
REQ-028 Reset then read all 32 indices -> every rs1_data/rs2_data = 0, busy_cnt = 0.
REQ-029 Write 0xDEADBEEF to r5, write 0x1234 to r0, read r5/r0 next cycle -> 0xDEADBEEF / 0x00000000.
REQ-030 Issue r7, r9, r7 on three cycles -> busy_cnt 1,2,2; rs1_addr=7 gives stall=1; writeback r7 -> busy_cnt 1, stall=0.
REQ-031 Same edge iss_en r3 and wr_en r3 data 0xA5 (r3 busy before) -> r3 reads 0xA5, rs1_busy=1, busy_cnt unchanged.
REQ-032 r4 busy, rs1_addr=4, wr_en r4 data 0x55 same cycle -> with REGFILE_WR_BYPASS_EN: rs1_data=0x55, stall=0 that cycle; without: old value, stall=1.
REQ-033 Issue r1..r10, assert rst_n=0 mid-clock -> busy_cnt=0 and stall=0 immediately, before the next edge.
